// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the board-game LED position encoder: the capture
// FSM state encoding, board geometry, die range and the legal-step test.
// No ports (package).
// ---------------------------------------------------------------------------
package game_pkg;

    // Number of squares on the board, one LED per square.
    localparam int BOARD_SIZE = 16;

    // Largest value a single die throw can produce.
    localparam int MAX_DIE = 6;

    // Widths derived from the board size.
    localparam int IDX_W = $clog2(BOARD_SIZE);
    localparam int CNT_W = $clog2(BOARD_SIZE) + 1;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // A plain die move: forward only, by at most MAX_DIE squares.
    // The ">=" guard is evaluated first so the subtraction never wraps.
    function automatic logic step_ok(input logic [IDX_W-1:0] cur,
                                     input logic [IDX_W-1:0] nxt);
        logic ok;
        ok = 1'b0;
        if (nxt >= cur) begin
            ok = ((nxt - cur) <= IDX_W'(MAX_DIE));
        end
        return ok;
    endfunction

endpackage

// File: rtl/led_position_encoder_if.sv
// ---------------------------------------------------------------------------
// led_position_encoder_if
// Bundles the LED bus, the sample strobe and all result outputs of the
// position encoder.
//   slave  : the encoder (takes led_in/sample, drives results)
//   master : whoever drives the board LEDs and reads the results
// Signals:
//   led_in[15:0] one-hot board LEDs      sample    capture strobe
//   busy         capture in progress     pos[3:0]  last accepted square
//   pos_valid    one-cycle update pulse  err_none/err_multi/err_step
//   jump         ladder/snake transfer   win       sticky goal reached
//   move_cnt[7:0] accepted-move count
// ---------------------------------------------------------------------------
interface led_position_encoder_if;
    import game_pkg::*;

    logic [BOARD_SIZE-1:0] led_in;
    logic                  sample;
    logic                  busy;
    logic [IDX_W-1:0]      pos;
    logic                  pos_valid;
    logic                  err_none;
    logic                  err_multi;
    logic                  err_step;
    logic                  jump;
    logic                  win;
    logic [7:0]            move_cnt;

    modport slave (
        input  led_in, sample,
        output busy, pos, pos_valid, err_none, err_multi, err_step,
               jump, win, move_cnt
    );

    modport master (
        output led_in, sample,
        input  busy, pos, pos_valid, err_none, err_multi, err_step,
               jump, win, move_cnt
    );

endinterface

// File: rtl/onehot_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc
// Purely combinational encoder for the LED snapshot.
// Ports:
//   vec[15:0] : LED snapshot
//   idx[3:0]  : index of the lowest set bit (0 when vec is zero)
//   cnt[4:0]  : number of set bits
// idx is only meaningful when cnt == 1; the caller rejects other counts.
// ---------------------------------------------------------------------------
module onehot_enc
    import game_pkg::*;
(
    input  logic [BOARD_SIZE-1:0] vec,
    output logic [IDX_W-1:0]      idx,
    output logic [CNT_W-1:0]      cnt
);

    // Scanning downward lets the lowest set bit win the index.
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = BOARD_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/led_position_encoder.sv
// ---------------------------------------------------------------------------
// led_position_encoder
// Reads a one-hot board LED bus for one player on request, validates the
// move against the previous position (die step, ladder, snake) and reports
// the new square plus error/jump/win flags.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : led_position_encoder_if.slave (led_in, sample in; busy, pos,
//           pos_valid, err_none, err_multi, err_step, jump, win,
//           move_cnt out)
//
// Timing: sample seen in cycle N -> busy from N+1, encode in N+1, decision
// in N+2, results and the pos_valid pulse registered at the end of N+2.
//
// Configuration macro: LED_POS_STATS_EN
//   defined   : move_cnt counts accepted moves, saturating at 255
//   undefined : move_cnt is tied to 0 and no counter is built
// ---------------------------------------------------------------------------
module led_position_encoder
    import game_pkg::*;
#(
    parameter int WIN_POS     = 15,
    parameter int LADDER_FROM = 3,
    parameter int LADDER_TO   = 9,
    parameter int SNAKE_FROM  = 11,
    parameter int SNAKE_TO    = 0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    led_position_encoder_if.slave bus
);

    localparam logic [IDX_W-1:0] WIN_SQ         = IDX_W'(WIN_POS);
    localparam logic [IDX_W-1:0] LADDER_FROM_SQ = IDX_W'(LADDER_FROM);
    localparam logic [IDX_W-1:0] LADDER_TO_SQ   = IDX_W'(LADDER_TO);
    localparam logic [IDX_W-1:0] SNAKE_FROM_SQ  = IDX_W'(SNAKE_FROM);
    localparam logic [IDX_W-1:0] SNAKE_TO_SQ    = IDX_W'(SNAKE_TO);

    state_t                state;
    logic [BOARD_SIZE-1:0] snap;
    logic [IDX_W-1:0]      enc_idx;
    logic [CNT_W-1:0]      enc_cnt;
    logic [IDX_W-1:0]      idx_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [IDX_W-1:0]      pos_r;
    logic                  busy_r;
    logic                  pos_valid_r;
    logic                  err_none_r;
    logic                  err_multi_r;
    logic                  err_step_r;
    logic                  jump_r;
    logic                  win_r;

    logic                  accept;
    logic                  take_jump;
    logic                  set_none;
    logic                  set_multi;
    logic                  set_step;

    onehot_enc u_enc (
        .vec (snap),
        .idx (enc_idx),
        .cnt (enc_cnt)
    );

    // Move decision, evaluated from the registered encode results.
    // Ladder foot and snake head are never legal resting squares, so they
    // are rejected before the die-step test even if the step is in range.
    // A ladder/snake destination only counts as a jump when it could not
    // have been reached by an ordinary die step.
    always_comb begin
        accept    = 1'b0;
        take_jump = 1'b0;
        set_none  = 1'b0;
        set_multi = 1'b0;
        set_step  = 1'b0;
        if (cnt_r == '0) begin
            set_none = 1'b1;
        end else if (cnt_r != CNT_W'(1)) begin
            set_multi = 1'b1;
        end else if (idx_r == LADDER_FROM_SQ || idx_r == SNAKE_FROM_SQ) begin
            set_step = 1'b1;
        end else if (step_ok(pos_r, idx_r)) begin
            accept = 1'b1;
        end else if (idx_r == LADDER_TO_SQ || idx_r == SNAKE_TO_SQ) begin
            accept    = 1'b1;
            take_jump = 1'b1;
        end else begin
            set_step = 1'b1;
        end
    end

    // Capture sequencer with registered outputs. pos_valid defaults low so
    // it is a single-cycle pulse; flags are only rewritten in CHECK so they
    // hold between captures. DONE absorbs every further sample until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            snap        <= '0;
            idx_r       <= '0;
            cnt_r       <= '0;
            pos_r       <= '0;
            busy_r      <= 1'b0;
            pos_valid_r <= 1'b0;
            err_none_r  <= 1'b0;
            err_multi_r <= 1'b0;
            err_step_r  <= 1'b0;
            jump_r      <= 1'b0;
            win_r       <= 1'b0;
        end else begin
            pos_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample) begin
                        snap   <= bus.led_in;
                        busy_r <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    idx_r <= enc_idx;
                    cnt_r <= enc_cnt;
                    state <= CHECK;
                end
                CHECK: begin
                    busy_r      <= 1'b0;
                    pos_valid_r <= 1'b1;
                    err_none_r  <= set_none;
                    err_multi_r <= set_multi;
                    err_step_r  <= set_step;
                    jump_r      <= take_jump;
                    state       <= IDLE;
                    if (accept) begin
                        pos_r <= idx_r;
                        if (idx_r == WIN_SQ) begin
                            win_r <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LED_POS_STATS_EN
    logic [7:0] move_cnt_r;

    // Accepted-move counter; sticks at 255 instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            move_cnt_r <= '0;
        end else if (state == CHECK && accept && move_cnt_r != 8'hFF) begin
            move_cnt_r <= move_cnt_r + 8'd1;
        end
    end

    assign bus.move_cnt = move_cnt_r;
`else
    assign bus.move_cnt = '0;
`endif

    assign bus.busy      = busy_r;
    assign bus.pos       = pos_r;
    assign bus.pos_valid = pos_valid_r;
    assign bus.err_none  = err_none_r;
    assign bus.err_multi = err_multi_r;
    assign bus.err_step  = err_step_r;
    assign bus.jump      = jump_r;
    assign bus.win       = win_r;

endmodule
